// File: rtl/bm_mac_pipe_if.sv
// Operand and result bundle for the block-minifloat MAC pipe.
// The slave side is the MAC engine. The master side is the operand-fetch
// stage, which also consumes the frame results.
interface bm_mac_pipe_if #(
  parameter int MAN_W = 5,
  parameter int EXP_W = 2,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_first;
  logic             in_last;
  logic             sign_a;
  logic             sign_b;
  logic             denorm_a;
  logic             denorm_b;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic             out_valid;
  logic [ACC_W-1:0] res;
  logic             ovf;

  modport master (
    output in_valid, in_first, in_last, sign_a, sign_b, denorm_a, denorm_b,
           exp_a, exp_b, man_a, man_b,
    input  out_valid, res, ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, sign_a, sign_b, denorm_a, denorm_b,
           exp_a, exp_b, man_a, man_b,
    output out_valid, res, ovf
  );
endinterface

// File: rtl/bm_mac_pipe.sv
// Pipelined block-minifloat multiply-accumulate engine.
// The pipe has four stages: S1 operand register, S2 multiply,
// S3 shift and sign, S4 saturating accumulate. A fifth register publishes
// each completed frame sum. The pipe has no backpressure and accepts one
// element per cycle.
module bm_mac_pipe #(
  parameter int MAN_W = 5,
  parameter int EXP_W = 2,
  parameter int ACC_W = 24
) (
  input  logic           clk,
  input  logic           rst,
  bm_mac_pipe_if.slave   bus
);
  localparam int SIG_W  = MAN_W + 1;
  localparam int MUL_W  = 2 * SIG_W;
  localparam int ES_W   = EXP_W + 1;
  localparam int PROD_W = MUL_W + 2 * (2 ** EXP_W - 1);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // ---------------- S1: registered operands ----------------
  logic             s1_valid, s1_first, s1_last, s1_sign;
  logic [SIG_W-1:0] s1_sig_a, s1_sig_b;
  logic [ES_W-1:0]  s1_esum;

  // Capture operands; the hidden bit is the inverse of the denorm flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sig_a <= '0;
      s1_sig_b <= '0;
      s1_esum  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_first <= bus.in_valid & bus.in_first;
      s1_last  <= bus.in_valid & bus.in_last;
      s1_sign  <= bus.sign_a ^ bus.sign_b;
      s1_sig_a <= {~bus.denorm_a, bus.man_a};
      s1_sig_b <= {~bus.denorm_b, bus.man_b};
      s1_esum  <= ES_W'(bus.exp_a) + ES_W'(bus.exp_b);
    end
  end

  // ---------------- S2: unsigned significand product ----------------
  logic             s2_valid, s2_first, s2_last, s2_sign;
  logic [MUL_W-1:0] s2_mag;
  logic [ES_W-1:0]  s2_esum;

  // Multiply significands; the exponent sum rides along for S3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
      s2_esum  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sign  <= s1_sign;
      s2_mag   <= MUL_W'(s1_sig_a) * MUL_W'(s1_sig_b);
      s2_esum  <= s1_esum;
    end
  end

  // ---------------- S3: align and convert to signed ----------------
  logic [PROD_W-1:0] s2_shift;
  logic [ACC_W-1:0]  s2_ext;
  logic              s2_neg;

  // Shift by the exponent sum. Only a non-zero magnitude is negated, so
  // a zero product is always +0.
  always_comb begin
    s2_shift = PROD_W'(s2_mag) << s2_esum;
    s2_ext   = ACC_W'(s2_shift);
    s2_neg   = s2_sign && (s2_shift != '0);
  end

  logic             s3_valid, s3_first, s3_last;
  logic [ACC_W-1:0] s3_prod;

  // Register the signed product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
      s3_prod  <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      s3_last  <= s2_last;
      s3_prod  <= s2_neg ? -s2_ext : s2_ext;
    end
  end

  // ---------------- S4: saturating accumulate ----------------
  logic [ACC_W-1:0] acc, acc_base, acc_new;
  logic [ACC_W:0]   acc_sum;
  logic             acc_sat;
  logic             ovf_sticky;
  logic             emit_pend;

  // A frame-opening element starts from zero, which discards any open
  // frame. A one-bit guard extension detects overflow.
  always_comb begin
    acc_base = s3_first ? '0 : acc;
    acc_sum  = {acc_base[ACC_W-1], acc_base} + {s3_prod[ACC_W-1], s3_prod};
    acc_sat  = acc_sum[ACC_W] != acc_sum[ACC_W-1];
    acc_new  = acc_sat ? (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                       : acc_sum[ACC_W-1:0];
  end

  // Update the accumulator and sticky flag for valid elements only; bubbles hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      emit_pend  <= 1'b0;
    end else begin
      emit_pend <= s3_valid & s3_last;
      if (s3_valid) begin
        acc        <= acc_new;
        ovf_sticky <= acc_sat | (~s3_first & ovf_sticky);
      end
    end
  end

  // ---------------- Result publication ----------------
  logic             out_valid_reg;
  logic [ACC_W-1:0] res_reg;
  logic             ovf_reg;

  // Publish the closed frame one edge after its last element accumulates.
  // res and ovf hold their values between emissions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      res_reg       <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      out_valid_reg <= emit_pend;
      if (emit_pend) begin
        res_reg <= acc;
        ovf_reg <= ovf_sticky;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.res       = res_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_bm_mac_pipe.sv
// Directed testbench for bm_mac_pipe with hand-computed frame sums.
module tb_bm_mac_pipe;
  localparam int MAN_W = 5;
  localparam int EXP_W = 2;
  localparam int ACC_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bm_mac_pipe_if #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(ACC_W)) bus();

  bm_mac_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every out_valid pulse is recorded with its cycle number
  int q_res[$];
  bit q_ovf[$];
  int q_cyc[$];
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q_res.push_back(int'(bus.res));
      q_ovf.push_back(bus.ovf);
      q_cyc.push_back(cyc);
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int last_sent = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send(input bit f, input bit l, input bit sa, input bit sb,
                      input bit da, input bit db,
                      input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb,
                      input logic [MAN_W-1:0] ma, input logic [MAN_W-1:0] mb);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_last  = l;
    bus.sign_a   = sa;
    bus.sign_b   = sb;
    bus.denorm_a = da;
    bus.denorm_b = db;
    bus.exp_a    = ea;
    bus.exp_b    = eb;
    bus.man_a    = ma;
    bus.man_b    = mb;
    last_sent    = cyc + 1;
    $display("send first=%0d last=%0d sa=%0d da=%0d db=%0d exp=%0d/%0d man=%0d/%0d edge=%0d",
             f, l, sa, da, db, ea, eb, ma, mb, last_sent);
  endtask

  // Product 3844 (denormals, man 31, exp 1/1), optionally negated via sign_a
  task automatic send_e3844(input bit f, input bit l, input bit sa);
    send(f, l, sa, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 5'd31, 5'd31);
  endtask

  // Normals with man 0: product 1024 << (2*e)
  task automatic send_n(input bit f, input bit l, input logic [EXP_W-1:0] e);
    send(f, l, 1'b0, 1'b0, 1'b0, 1'b0, e, e, 5'd0, 5'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  // Pop one recorded emission and compare it
  task automatic take(input string tag, input int exp_res, input bit exp_ovf, output int c);
    c = -1;
    if (q_res.size() == 0) begin
      check({tag, " present"}, 0, 1);
    end else begin
      check({tag, " res"}, q_res.pop_front(), exp_res);
      check({tag, " ovf"}, q_ovf.pop_front(), exp_ovf);
      c = q_cyc.pop_front();
      $display("emit %s res=%0d cycle=%0d", tag, exp_res, c);
    end
  endtask

  initial begin
    int c0, c1, sent;
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
    bus.sign_a = 0; bus.sign_b = 0; bus.denorm_a = 0; bus.denorm_b = 0;
    bus.exp_a = '0; bus.exp_b = '0; bus.man_a = '0; bus.man_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset res", bus.res, 0);
    check("reset ovf", bus.ovf, 0);
    rst = 1'b0;
    idle(2);

    // Single element frame with 4-cycle latency
    send_e3844(1, 1, 0);
    sent = last_sent;
    idle(8);
    check("single count", q_res.size(), 1);
    take("single", 3844, 0, c0);
    check("single latency", c0 - sent, 4);

    // Negative product and signed zero
    send_e3844(1, 1, 1);
    idle(8);
    check("neg count", q_res.size(), 1);
    take("neg", 24'hFFF0FC, 0, c0);
    send(1, 1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 5'd0, 5'd31);
    idle(8);
    check("zero count", q_res.size(), 1);
    take("zero", 0, 0, c0);
    check("zero res held", bus.res, 0);

    // Three elements with a bubble before the last one
    send_n(1, 0, 0);
    send_n(0, 0, 0);
    idle(1);
    send_n(0, 1, 0);
    idle(8);
    check("bubble count", q_res.size(), 1);
    take("bubble", 3072, 0, c0);

    // Positive saturation, then a clean frame clears the sticky flag
    for (int i = 0; i < 128; i++) send_n(i == 0, i == 127, 2'd3);
    idle(8);
    check("sat count", q_res.size(), 1);
    take("sat", 8388607, 1, c0);
    send_n(1, 1, 0);
    idle(8);
    check("after sat count", q_res.size(), 1);
    take("after sat", 1024, 0, c0);

    // Back-to-back frames
    send_e3844(1, 1, 0);
    send_e3844(1, 0, 0);
    send_e3844(0, 1, 0);
    idle(8);
    check("b2b count", q_res.size(), 2);
    take("b2b frame1", 3844, 0, c0);
    take("b2b frame2", 7688, 0, c1);
    check("b2b spacing", c1 - c0, 2);

    // A new first abandons the open frame
    send_n(1, 0, 0);
    send_e3844(1, 1, 0);
    idle(8);
    check("abandon count", q_res.size(), 1);
    take("abandon", 3844, 0, c0);

    // Reset while an element is in flight
    send_e3844(1, 1, 0);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(8);
    check("rst mid count", q_res.size(), 0);
    check("rst mid out_valid", bus.out_valid, 0);
    check("rst mid res", bus.res, 0);
    check("rst mid ovf", bus.ovf, 0);
    send_e3844(1, 1, 0);
    sent = last_sent;
    idle(8);
    check("post rst count", q_res.size(), 1);
    take("post rst", 3844, 0, c0);
    check("post rst latency", c0 - sent, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
